// File: rtl/fetch_pkg.sv
// Shared types for the operand fetch unit: addressing modes, fetch FSM states
// and per-mode operand-byte / pointer-phase lookup tables.
package fetch_pkg;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, IND, X_IND, IND_Y, REL
    } addr_mode_e;

    typedef enum logic [3:0] {
        IDLE, OP_REQ, OP_WAIT, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT,
        PL_REQ, PL_WAIT, PH_REQ, PH_WAIT, CALC, DONE
    } fetch_state_e;

    // One bit per addressing mode, indexed by the mode encoding.
    localparam logic [15:0] MODE_TWO_BYTES = (16'd1 << ABS) | (16'd1 << ABS_X) |
                                             (16'd1 << ABS_Y) | (16'd1 << IND);
    localparam logic [15:0] MODE_ONE_BYTE  = (16'd1 << IMM) | (16'd1 << ZPG) |
                                             (16'd1 << ZPG_X) | (16'd1 << ZPG_Y) |
                                             (16'd1 << X_IND) | (16'd1 << IND_Y) |
                                             (16'd1 << REL);
    localparam logic [15:0] MODE_PTR       = (16'd1 << IND) | (16'd1 << X_IND) |
                                             (16'd1 << IND_Y);

    function automatic logic [1:0] operand_bytes(input addr_mode_e m);
        if (MODE_TWO_BYTES[m]) return 2'd2;
        if (MODE_ONE_BYTE[m])  return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic has_ptr(input addr_mode_e m);
        return MODE_PTR[m];
    endfunction

endpackage

// File: rtl/addr_mode_decode.sv
// Combinational 6502 opcode -> addressing mode decode using the aaa/bbb/cc
// field split. Anything unofficial falls back to IMP.
import fetch_pkg::*;

module addr_mode_decode (
    input  logic [7:0]  opcode,
    output addr_mode_e  mode
);

    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;

    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    always_comb begin
        mode = IMP;
        case (cc)
            2'b01: begin
                case (bbb)
                    3'd0: mode = X_IND;
                    3'd1: mode = ZPG;
                    3'd2: mode = (aaa == 3'd4) ? IMP : IMM;   // 0x89 has no STA #imm
                    3'd3: mode = ABS;
                    3'd4: mode = IND_Y;
                    3'd5: mode = ZPG_X;
                    3'd6: mode = ABS_Y;
                    default: mode = ABS_X;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: if (aaa == 3'd5) mode = IMM;
                    3'd1: mode = ZPG;
                    3'd2: if (!aaa[2]) mode = ACC;
                    3'd3: mode = ABS;
                    // STX/LDX index with Y instead of X
                    3'd5: mode = (aaa[2:1] == 2'b10) ? ZPG_Y : ZPG_X;
                    3'd7: begin
                        if (aaa == 3'd5)      mode = ABS_Y;
                        else if (aaa != 3'd4) mode = ABS_X;
                    end
                    default: mode = IMP;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: begin
                        if (aaa == 3'd1)      mode = ABS;
                        else if (aaa >= 3'd5) mode = IMM;
                    end
                    3'd1: if (aaa == 3'd1 || aaa >= 3'd4) mode = ZPG;
                    3'd3: begin
                        if (aaa == 3'd3)      mode = IND;
                        else if (aaa != 3'd0) mode = ABS;
                    end
                    3'd4: mode = REL;
                    3'd5: if (aaa[2:1] == 2'b10) mode = ZPG_X;
                    3'd7: if (aaa == 3'd5) mode = ABS_X;
                    default: mode = IMP;
                endcase
            end
            default: mode = IMP;
        endcase
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Fetches opcode + operand bytes over a variable-latency read handshake,
// dereferences pointers and resolves the effective address; owns the PC.
import fetch_pkg::*;

module operand_fetch_unit #(
    parameter int                    REG_WIDTH    = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
    parameter bit                    JMP_IND_BUG  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_rvalid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done,
    output logic [REG_WIDTH-1:0]  opcode,
    output logic [3:0]            mode,
    output logic [REG_WIDTH-1:0]  operand,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic                  page_cross
);

    localparam int                    HI_W    = ADDR_WIDTH - REG_WIDTH;
    localparam logic [REG_WIDTH-1:0]  ONE_R   = REG_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [HI_W-1:0]       ZERO_HI = '0;

    fetch_state_e          state, state_nx;
    addr_mode_e            mode_r, dec_mode;
    logic [ADDR_WIDTH-1:0] pc_r, ea_r, ea_calc, ptr_lo_addr, ptr_hi_addr, rel_target;
    logic [REG_WIDTH-1:0]  x_r, y_r, opcode_r, b1_r, b2_r, plo_r, phi_r, zp_x;
    logic [REG_WIDTH:0]    b1_plus_x, b1_plus_y, plo_plus_y;
    logic                  pcx_r, pcx_calc;

    addr_mode_decode u_decode (
        .opcode (mem_rdata[7:0]),
        .mode   (dec_mode)
    );

    assign b1_plus_x  = {1'b0, b1_r} + {1'b0, x_r};
    assign b1_plus_y  = {1'b0, b1_r} + {1'b0, y_r};
    assign plo_plus_y = {1'b0, plo_r} + {1'b0, y_r};
    assign zp_x       = b1_plus_x[REG_WIDTH-1:0];
    assign rel_target = pc_r + {{HI_W{b1_r[REG_WIDTH-1]}}, b1_r};

    // Pointer fetch addresses; zero-page pointers wrap inside page zero.
    always_comb begin
        ptr_lo_addr = {ZERO_HI, b1_r};
        ptr_hi_addr = {ZERO_HI, b1_r + ONE_R};
        case (mode_r)
            IND: begin
                ptr_lo_addr = {b2_r, b1_r};
                ptr_hi_addr = JMP_IND_BUG ? {b2_r, b1_r + ONE_R} : ({b2_r, b1_r} + ONE_A);
            end
            X_IND: begin
                ptr_lo_addr = {ZERO_HI, zp_x};
                ptr_hi_addr = {ZERO_HI, zp_x + ONE_R};
            end
            default: ;
        endcase
    end

    // Indexed modes add with a split low/high carry so the carry doubles as page_cross.
    always_comb begin
        ea_calc  = '0;
        pcx_calc = 1'b0;
        case (mode_r)
            IMM:   ea_calc = pc_r - ONE_A;
            ZPG:   ea_calc = {ZERO_HI, b1_r};
            ZPG_X: ea_calc = {ZERO_HI, zp_x};
            ZPG_Y: ea_calc = {ZERO_HI, b1_plus_y[REG_WIDTH-1:0]};
            ABS:   ea_calc = {b2_r, b1_r};
            ABS_X: begin
                ea_calc  = {b2_r + (b1_plus_x[REG_WIDTH] ? ONE_R : '0), b1_plus_x[REG_WIDTH-1:0]};
                pcx_calc = b1_plus_x[REG_WIDTH];
            end
            ABS_Y: begin
                ea_calc  = {b2_r + (b1_plus_y[REG_WIDTH] ? ONE_R : '0), b1_plus_y[REG_WIDTH-1:0]};
                pcx_calc = b1_plus_y[REG_WIDTH];
            end
            IND, X_IND: ea_calc = {phi_r, plo_r};
            IND_Y: begin
                ea_calc  = {phi_r + (plo_plus_y[REG_WIDTH] ? ONE_R : '0), plo_plus_y[REG_WIDTH-1:0]};
                pcx_calc = plo_plus_y[REG_WIDTH];
            end
            REL: begin
                ea_calc  = rel_target;
                pcx_calc = rel_target[ADDR_WIDTH-1:REG_WIDTH] != pc_r[ADDR_WIDTH-1:REG_WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_addr = '0;
        case (state)
            IDLE:    if (!pc_load && start) state_nx = OP_REQ;
            OP_REQ:  begin mem_rd = 1'b1; mem_addr = pc_r; state_nx = OP_WAIT; end
            OP_WAIT: if (mem_rvalid)
                         state_nx = (operand_bytes(dec_mode) != 2'd0) ? B1_REQ : CALC;
            B1_REQ:  begin mem_rd = 1'b1; mem_addr = pc_r; state_nx = B1_WAIT; end
            B1_WAIT: if (mem_rvalid) begin
                         if (operand_bytes(mode_r) == 2'd2) state_nx = B2_REQ;
                         else if (has_ptr(mode_r))         state_nx = PL_REQ;
                         else                               state_nx = CALC;
                     end
            B2_REQ:  begin mem_rd = 1'b1; mem_addr = pc_r; state_nx = B2_WAIT; end
            B2_WAIT: if (mem_rvalid) state_nx = has_ptr(mode_r) ? PL_REQ : CALC;
            PL_REQ:  begin mem_rd = 1'b1; mem_addr = ptr_lo_addr; state_nx = PL_WAIT; end
            PL_WAIT: if (mem_rvalid) state_nx = PH_REQ;
            PH_REQ:  begin mem_rd = 1'b1; mem_addr = ptr_hi_addr; state_nx = PH_WAIT; end
            PH_WAIT: if (mem_rvalid) state_nx = CALC;
            CALC:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_r     <= RESET_VECTOR;
            mode_r   <= IMP;
            x_r      <= '0;
            y_r      <= '0;
            opcode_r <= '0;
            b1_r     <= '0;
            b2_r     <= '0;
            plo_r    <= '0;
            phi_r    <= '0;
            ea_r     <= '0;
            pcx_r    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc_r <= pc_load_value;
                    end else if (start) begin
                        x_r   <= x_in;
                        y_r   <= y_in;
                        b1_r  <= '0;
                        ea_r  <= '0;
                        pcx_r <= 1'b0;
                    end
                end
                OP_WAIT: if (mem_rvalid) begin
                    opcode_r <= mem_rdata;
                    mode_r   <= dec_mode;
                    pc_r     <= pc_r + ONE_A;
                end
                B1_WAIT: if (mem_rvalid) begin
                    b1_r <= mem_rdata;
                    pc_r <= pc_r + ONE_A;
                end
                B2_WAIT: if (mem_rvalid) begin
                    b2_r <= mem_rdata;
                    pc_r <= pc_r + ONE_A;
                end
                PL_WAIT: if (mem_rvalid) plo_r <= mem_rdata;
                PH_WAIT: if (mem_rvalid) phi_r <= mem_rdata;
                CALC: begin
                    ea_r  <= ea_calc;
                    pcx_r <= pcx_calc;
                end
                default: ;
            endcase
        end
    end

    assign pc         = pc_r;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign opcode     = opcode_r;
    assign mode       = mode_r;
    assign operand    = b1_r;
    assign ea         = ea_r;
    assign page_cross = pcx_r;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomised bench for operand_fetch_unit against a table-driven 6502
// addressing model and a latency-programmable memory responder.
module tb_operand_fetch_unit;

    localparam bit BUG = 1'b1;
    localparam int M_IMP = 0, M_ACC = 1, M_IMM = 2, M_ZPG = 3, M_ZPG_X = 4, M_ZPG_Y = 5,
                   M_ABS = 6, M_ABS_X = 7, M_ABS_Y = 8, M_IND = 9, M_X_IND = 10,
                   M_IND_Y = 11, M_REL = 12;

    logic        clk = 1'b0;
    logic        reset, start, pc_load, mem_rd, mem_rvalid, busy, done, page_cross;
    logic [15:0] pc_load_value, mem_addr, pc, ea;
    logic [7:0]  x_in, y_in, mem_rdata, opcode, operand;
    logic [3:0]  mode;

    always #5 clk = ~clk;

    operand_fetch_unit #(.REG_WIDTH(8), .ADDR_WIDTH(16), .RESET_VECTOR(16'hFFFC),
                         .JMP_IND_BUG(BUG)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .x_in(x_in), .y_in(y_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .pc(pc), .busy(busy), .done(done),
        .opcode(opcode), .mode(mode), .operand(operand), .ea(ea),
        .page_cross(page_cross)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] seen[$];
    int          lat = 1;
    int          cnt;
    bit          pend;
    logic [15:0] paddr;
    int          rd_overlap;
    int          total = 0, bad = 0;
    int          cur_pc;
    int          e_mode, e_op, e_operand, e_ea, e_pc, e_pcx, e_nb;
    int          e_addrs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder: one outstanding read, data after 'lat' cycles.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        pend       = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[paddr];
                    pend       = 1'b0;
                end
            end
            if (mem_rd) begin
                if (pend) rd_overlap++;
                seen.push_back(mem_addr);
                pend  = 1'b1;
                cnt   = lat;
                paddr = mem_addr;
            end
        end
    end

    function automatic int rd(input int a);
        return int'(mem[a % 65536]);
    endfunction

    function automatic int ref_mode(input int op);
        case (op)
            'h0A, 'h2A, 'h4A, 'h6A: return M_ACC;
            'h09, 'h29, 'h49, 'h69, 'hA9, 'hC9, 'hE9, 'hA2, 'hA0, 'hC0, 'hE0: return M_IMM;
            'h05, 'h25, 'h45, 'h65, 'h85, 'hA5, 'hC5, 'hE5,
            'h06, 'h26, 'h46, 'h66, 'h86, 'hA6, 'hC6, 'hE6,
            'h24, 'h84, 'hA4, 'hC4, 'hE4: return M_ZPG;
            'h15, 'h35, 'h55, 'h75, 'h95, 'hB5, 'hD5, 'hF5,
            'h16, 'h36, 'h56, 'h76, 'hD6, 'hF6, 'h94, 'hB4: return M_ZPG_X;
            'h96, 'hB6: return M_ZPG_Y;
            'h0D, 'h2D, 'h4D, 'h6D, 'h8D, 'hAD, 'hCD, 'hED,
            'h0E, 'h2E, 'h4E, 'h6E, 'h8E, 'hAE, 'hCE, 'hEE,
            'h20, 'h2C, 'h4C, 'h8C, 'hAC, 'hCC, 'hEC: return M_ABS;
            'h1D, 'h3D, 'h5D, 'h7D, 'h9D, 'hBD, 'hDD, 'hFD,
            'h1E, 'h3E, 'h5E, 'h7E, 'hDE, 'hFE, 'hBC: return M_ABS_X;
            'h19, 'h39, 'h59, 'h79, 'h99, 'hB9, 'hD9, 'hF9, 'hBE: return M_ABS_Y;
            'h6C: return M_IND;
            'h01, 'h21, 'h41, 'h61, 'h81, 'hA1, 'hC1, 'hE1: return M_X_IND;
            'h11, 'h31, 'h51, 'h71, 'h91, 'hB1, 'hD1, 'hF1: return M_IND_Y;
            'h10, 'h30, 'h50, 'h70, 'h90, 'hB0, 'hD0, 'hF0: return M_REL;
            default: return M_IMP;
        endcase
    endfunction

    task automatic model(input int pc0, input int xv, input int yv);
        int b1, b2, lo_a, hi_a, lo, off;
        e_addrs.delete();
        e_op   = rd(pc0);
        e_mode = ref_mode(e_op);
        if (e_mode inside {M_ABS, M_ABS_X, M_ABS_Y, M_IND}) e_nb = 2;
        else if (e_mode inside {M_IMP, M_ACC})             e_nb = 0;
        else                                               e_nb = 1;
        for (int i = 0; i <= e_nb; i++) e_addrs.push_back((pc0 + i) % 65536);
        b1 = rd(pc0 + 1);
        b2 = rd(pc0 + 2);
        e_operand = b1;
        e_pc  = (pc0 + 1 + e_nb) % 65536;
        e_ea  = 0;
        e_pcx = 0;
        lo_a  = -1;
        hi_a  = -1;
        case (e_mode)
            M_IMM:   e_ea = (pc0 + 1) % 65536;
            M_ZPG:   e_ea = b1;
            M_ZPG_X: e_ea = (b1 + xv) % 256;
            M_ZPG_Y: e_ea = (b1 + yv) % 256;
            M_ABS:   e_ea = b2 * 256 + b1;
            M_ABS_X: begin e_ea = (b2 * 256 + b1 + xv) % 65536; e_pcx = int'(b1 + xv > 255); end
            M_ABS_Y: begin e_ea = (b2 * 256 + b1 + yv) % 65536; e_pcx = int'(b1 + yv > 255); end
            M_IND: begin
                lo_a = b2 * 256 + b1;
                hi_a = BUG ? b2 * 256 + (b1 + 1) % 256 : (lo_a + 1) % 65536;
            end
            M_X_IND: begin lo_a = (b1 + xv) % 256; hi_a = (lo_a + 1) % 256; end
            M_IND_Y: begin lo_a = b1; hi_a = (b1 + 1) % 256; end
            M_REL: begin
                off   = (b1 >= 128) ? b1 - 256 : b1;
                e_ea  = (e_pc + off + 65536) % 65536;
                e_pcx = int'((e_ea / 256) != (e_pc / 256));
            end
            default: ;
        endcase
        if (lo_a >= 0) begin
            e_addrs.push_back(lo_a);
            e_addrs.push_back(hi_a);
            lo = rd(lo_a);
            if (e_mode == M_IND_Y) begin
                e_ea  = (rd(hi_a) * 256 + lo + yv) % 65536;
                e_pcx = int'(lo + yv > 255);
            end else begin
                e_ea = rd(hi_a) * 256 + lo;
            end
        end
    endtask

    task automatic do_load(input int v);
        @(posedge clk); #1;
        pc_load = 1'b1; pc_load_value = 16'(v);
        @(posedge clk); #1;
        pc_load = 1'b0;
        cur_pc = v;
        chk("pc_load", 32'(pc), v);
    endtask

    // noise: hold start high and toggle pc_load throughout busy and the DONE cycle.
    task automatic run_instr(input int xv, input int yv, input int l, input bit noise);
        int cyc;
        lat = l;
        model(cur_pc, xv, yv);
        seen.delete();
        rd_overlap = 0;
        @(posedge clk); #1;
        start = 1'b1; x_in = 8'(xv); y_in = 8'(yv);
        @(posedge clk); #1;
        start = 1'b0; x_in = 8'($urandom); y_in = 8'($urandom);
        cyc = 1;
        chk("busy_after_start", 32'(busy), 1);
        while (!done && cyc < 400) begin
            if (noise) begin
                start = 1'b1; pc_load = 1'($urandom); pc_load_value = 16'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", 32'(done), 1);
        chk("latency", cyc, e_addrs.size() * (1 + l) + 2);
        chk("opcode", 32'(opcode), e_op);
        chk("mode", 32'(mode), e_mode);
        if (e_nb > 0) chk("operand", 32'(operand), e_operand);
        chk("ea", 32'(ea), e_ea);
        chk("page_cross", 32'(page_cross), e_pcx);
        chk("pc", 32'(pc), e_pc);
        @(posedge clk); #1;
        start = 1'b0; pc_load = 1'b0;
        chk("idle_after_done", {30'd0, busy, done}, 0);
        chk("pc_hold", 32'(pc), e_pc);
        chk("rd_count", seen.size(), e_addrs.size());
        for (int i = 0; i < seen.size() && i < e_addrs.size(); i++)
            chk($sformatf("rd_addr%0d", i), 32'(seen[i]), e_addrs[i]);
        chk("rd_one_cycle", rd_overlap, 0);
        cur_pc = e_pc;
    endtask

    initial begin
        int done_cnt, rd_cnt, guard;
        reset = 1'b1; start = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0;
        x_in = 8'h0; y_in = 8'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_pc", 32'(pc), 32'hFFFC);
        chk("rst_ctl", {28'd0, mem_rd, busy, done, page_cross}, 0);
        chk("rst_res", {opcode, operand, 12'd0, mode}, 0);
        chk("rst_ea", 32'(ea), 0);
        cur_pc = 'hFFFC;

        // IMM from the reset vector
        mem['hFFFC] = 8'hA9; mem['hFFFD] = 8'h42;
        run_instr(0, 0, 1, 1'b0);
        chk("imm_ea", 32'(ea), 32'hFFFD);

        // ABS_X with page crossing
        mem['h0200] = 8'hBD; mem['h0201] = 8'hFF; mem['h0202] = 8'h10;
        do_load('h0200);
        run_instr(1, 0, 1, 1'b0);
        chk("absx_ea", 32'(ea), 32'h1100);
        chk("absx_pcx", 32'(page_cross), 1);

        // X_IND with zero-page wrap, fast and slow memory
        mem['h0300] = 8'hA1; mem['h0301] = 8'hFE; mem['h0001] = 8'h34; mem['h0002] = 8'h12;
        do_load('h0300);
        run_instr(3, 0, 1, 1'b0);
        chk("xind_ea", 32'(ea), 32'h1234);
        do_load('h0300);
        run_instr(3, 0, 5, 1'b0);
        chk("xind_slow_ea", 32'(ea), 32'h1234);

        // JMP (ind) across a page boundary
        mem['h0400] = 8'h6C; mem['h0401] = 8'hFF; mem['h0402] = 8'h02;
        mem['h02FF] = 8'h00; mem['h0200] = 8'h80; mem['h0300] = 8'h90;
        do_load('h0400);
        run_instr(0, 0, 2, 1'b0);
        chk("jmp_ind_ea", 32'(ea), BUG ? 32'h8000 : 32'h9000);

        // Backward branch, start held high while busy
        mem['h0500] = 8'hF0; mem['h0501] = 8'hFC;
        do_load('h0500);
        run_instr(0, 0, 1, 1'b1);
        chk("rel_ea", 32'(ea), 32'h04FE);
        chk("rel_pcx", 32'(page_cross), 1);

        // pc_load wins over start in the same cycle
        @(posedge clk); #1;
        pc_load = 1'b1; start = 1'b1; pc_load_value = 16'h1234;
        @(posedge clk); #1;
        pc_load = 1'b0; start = 1'b0;
        chk("prio_busy", 32'(busy), 0);
        chk("prio_pc", 32'(pc), 32'h1234);
        cur_pc = 'h1234;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 65535)));
            run_instr(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(1, 4)), 1'($urandom));
        end

        // Reset while waiting on a pointer read; its late data must be ignored
        mem['h0600] = 8'hA1; mem['h0601] = 8'h10;
        do_load('h0600);
        lat = 5;
        seen.delete();
        @(posedge clk); #1;
        start = 1'b1; x_in = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (seen.size() < 3 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_pl_req", seen.size(), 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        done_cnt = 0;
        rd_cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            if (mem_rd) rd_cnt++;
            @(posedge clk); #1;
        end
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_rd", rd_cnt, 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_pc", 32'(pc), 32'hFFFC);
        chk("rst_mid_res", {opcode, 8'd0, ea}, 0);
        cur_pc = 'hFFFC;
        run_instr(0, 0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Parametrised successor to the core's instruction fetcher.
- Fetches the opcode and all operand bytes through a variable-latency read handshake.
- Resolves the effective address for all thirteen 6502 addressing modes, including pointer dereference for IND, X_IND and IND_Y.
- Owns the PC and reports page crossings. Sits between the memory arbiter and the execute stage.

Parameters:
- REG_WIDTH, 8: data/register width; must equal ADDR_WIDTH/2.
- ADDR_WIDTH, 16: address width.
- RESET_VECTOR, 16'hFFFC: PC value after reset.
- JMP_IND_BUG, 1: when 1, the IND high byte is read from {ptr_hi, ptr_lo+1}, so no page carry.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin fetch at PC; honoured only in IDLE
- pc_load  in  1  load PC; honoured only in IDLE
- pc_load_value  in  ADDR_WIDTH  new PC
- x_in, y_in  in  REG_WIDTH  index registers; sampled on accepted start
- mem_rd  out  1  one-cycle read request
- mem_addr  out  ADDR_WIDTH  read address; valid with mem_rd
- mem_rdata  in  REG_WIDTH  read data
- mem_rvalid  in  1  read data valid; latency >= 1 cycle after mem_rd
- pc  out  ADDR_WIDTH  current PC
- busy  out  1  high from accepted start through the cycle before done
- done  out  1  one-cycle pulse; result outputs valid
- opcode  out  REG_WIDTH  fetched opcode
- mode  out  4  decoded addressing mode
- operand  out  REG_WIDTH  first operand byte (immediate value for IMM)
- ea  out  ADDR_WIDTH  effective address
- page_cross  out  1  index/branch add crossed a page

Behaviour:
- Reset:
  - State IDLE; pc=RESET_VECTOR.
  - mem_rd, busy, done, page_cross all 0.
  - opcode, operand, ea, mode all 0.
  - Any outstanding read is abandoned; a later mem_rvalid in IDLE is ignored.
- States: IDLE, OP_REQ, OP_WAIT, B1_REQ, B1_WAIT, B2_REQ, B2_WAIT, PL_REQ, PL_WAIT, PH_REQ, PH_WAIT, CALC, DONE.
  - Each *_REQ asserts mem_rd for exactly one cycle.
  - Each *_WAIT holds until mem_rvalid. A mem_rvalid arriving outside a *_WAIT state is ignored.
- IDLE:
  - pc_load has priority over start in the same cycle.
  - start accepted -> OP_REQ next cycle, with mem_addr=pc; x/y latched.
- Opcode and operand bytes:
  - Each opcode/operand byte read increments pc by 1 (mod 2^ADDR_WIDTH) on its mem_rvalid.
  - After the opcode, mode comes from the decoder, which selects how many operand bytes to read (0/1/2) and whether to do a pointer phase (PL/PH).
- Effective address, all byte sums mod 256 unless stated otherwise:
  - IMP/ACC: ea=0. Minimum latency: start -> done in 4 cycles with rvalid latency 1.
  - IMM: ea=address of operand byte; operand=b1.
  - ZPG: {00,b1}.
  - ZPG_X / ZPG_Y: {00,b1+x} / {00,b1+y}. Zero-page wrap; page_cross=0.
  - ABS: {b2,b1}.
  - ABS_X / ABS_Y: {b2,b1}+index mod 2^16; page_cross=carry out of the low byte.
  - IND: ptr={b2,b1}; lo@ptr; hi@ptr+1, or @{b2,b1+1} when JMP_IND_BUG=1.
  - X_IND: p=b1+x; lo@{00,p}; hi@{00,p+1}.
  - IND_Y: lo@{00,b1}; hi@{00,b1+1}; ea={hi,lo}+y; page_cross as for ABS_Y.
  - REL: ea=pc_after_operand+sign_extend(b1); page_cross when ea[15:8] != pc_after[15:8].
- Completion:
  - CALC lasts one cycle. DONE pulses done=1 for one cycle, then returns to IDLE.
  - Results hold until the next accepted start.
- Ignored inputs:
  - start or pc_load while busy is ignored, with no side effect.
  - start in the DONE cycle is ignored.
- Reset while busy: abandon immediately, regardless of state.

Decomposition:
- Package fetch_pkg holds:
  - addr_mode enum: IMP, ACC, IMM, ZPG, ZPG_X, ZPG_Y, ABS, ABS_X, ABS_Y, IND, X_IND, IND_Y, REL.
  - Fetch state enum.
  - Operand-byte-count and pointer-phase lookup constants.
- Sub-module addr_mode_decode: combinational opcode -> mode via the 6502 aaa/bbb/cc field table. Unofficial opcodes map to IMP.

Test Plan:
- Reset, then start with mem[FFFC]=A9, mem[FFFD]=42, rvalid latency 1 -> mode=IMM, operand=42, ea=FFFD, pc=FFFE, done after 6 cycles.
- pc_load 0200, mem[0200..0202]=BD FF 10, x=01 -> ABS_X, ea=1100, page_cross=1, pc=0203.
- mem[0300..0301]=A1 FE, x=03, mem[0001..0002]=34 12 -> X_IND, pointer wraps to 01, ea=1234. Repeat with rvalid latency 5 -> same result, done later, mem_rd strictly one cycle per read.
- JMP ind: mem[0400..0402]=6C FF 02, mem[02FF]=00, mem[0200]=80, mem[0300]=90 -> ea=8000 with JMP_IND_BUG=1, ea=9000 with JMP_IND_BUG=0.
- REL at 0500: F0 FC -> ea=04FE, page_cross=1. Assert start during busy -> ignored, no extra mem_rd.
- Reset asserted in PL_WAIT, then a stale mem_rvalid -> IDLE, pc=FFFC, done never pulses.
